sevenseg_scan: RTL and testbench

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

---
 rtl/sevenseg_scan.sv | 150 +++++++++++++++
 tb/tb_sevenseg_scan.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed seven-segment display driver.
// Digit data is double-buffered and only swapped at frame boundaries.
module sevenseg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1024,
  parameter int GHOST          = 2,
  parameter int HEX_EN         = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         act_val, pend_val;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp;
  logic [NUM_DIGITS-1:0] act_en, pend_en;
  logic                  pend_flag;
  logic                  slot_end, frame_end;
  logic                  ghost;
  logic [VW-1:0]         hi;
  logic [NUM_DIGITS-1:0] sel;
  logic                  blank;
  logic [6:0]            seg_l;
  logic                  dp_l;
  logic [NUM_DIGITS-1:0] an_l;

  assign slot_end  = (presc == P_LAST);
  assign frame_end = slot_end && (idx == I_LAST);

  if (GHOST > 0) begin : g_ghost
    assign ghost = (presc < PW'(GHOST));
  end else begin : g_noghost
    assign ghost = 1'b0;
  end

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
      default: s = 7'h00;
    endcase
    if (HEX_EN == 0 && n > 4'h9) s = 7'h00;
    return s;
  endfunction

  // slot prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= slot_end ? '0 : presc + PW'(1);
      if (slot_end) idx <= (idx == I_LAST) ? '0 : idx + IW'(1);
    end
  end

  // pending capture; active swap only at the frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_val   <= '0;
      act_dp    <= '0;
      act_en    <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_en   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_en  <= digit_en;
      end
      if (frame_end) begin
        pend_flag <= 1'b0;
        if (load) begin
          act_val <= value;
          act_dp  <= dp_in;
          act_en  <= digit_en;
        end else if (pend_flag) begin
          act_val <= pend_val;
          act_dp  <= pend_dp;
          act_en  <= pend_en;
        end
      end else if (load) begin
        pend_flag <= 1'b1;
      end
    end
  end

  // digit pattern for the current slot, before polarity
  always_comb begin
    hi    = act_val >> {idx, 2'b00};
    sel   = NUM_DIGITS'(1) << idx;
    blank = lz_en && (idx != '0) && (hi == '0);
    seg_l = blank ? 7'h00 : decode(hi[3:0]);
    dp_l  = !blank && |(act_dp & sel);
    an_l  = ghost ? '0 : (act_en & sel);
  end

  // registered pins, polarity applied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= {7{SEG_INV}};
      dp         <= SEG_INV;
      an         <= {NUM_DIGITS{AN_INV}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_l ^ {7{SEG_INV}};
      dp         <= dp_l ^ SEG_INV;
      an         <= an_l ^ {NUM_DIGITS{AN_INV}};
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: scenario tasks plus a randomized run
// compared against a cycle-count based display model.
module tb_sevenseg_scan;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int G  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;
  logic [3:0]  an, an2;
  logic        frame_tick, frame_tick2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .GHOST(G),
    .HEX_EN(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) u_hex (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .lz_en(lz_en), .load(load),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  sevenseg_scan #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .GHOST(G),
    .HEX_EN(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) u_dec (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .lz_en(lz_en), .load(load),
    .seg(seg2), .dp(dp2), .an(an2), .frame_tick(frame_tick2)
  );

  logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79,
                           7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F,
                           7'h4E, 7'h3D, 7'h4F, 7'h47};

  // model: time t counts clocks since reset; slot/phase follow arithmetically
  int          m_t;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp, m_en, p_en;
  logic        m_flag;
  logic [6:0]  e_seg, e_seg2;
  logic        e_dp, e_ft;
  logic [3:0]  e_an;

  function automatic int slot_of(int t);
    return (t / SD) % N;
  endfunction

  function automatic bit at_boundary(int t);
    return ((t % SD) == SD - 1) && (slot_of(t) == N - 1);
  endfunction

  function automatic bit is_blank(int t, logic [15:0] v, logic lz);
    int i;
    i = slot_of(t);
    if (!lz || i == 0) return 1'b0;
    for (int j = i; j < N; j++)
      if (v[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [6:0] exp_seg(int t, logic [15:0] v,
                                         logic lz, bit hex);
    logic [3:0] n;
    n = v[4*slot_of(t) +: 4];
    if (is_blank(t, v, lz)) return 7'h00;
    if (!hex && n > 4'd9) return 7'h00;
    return tbl[n];
  endfunction

  function automatic logic [3:0] exp_an(int t, logic [3:0] en);
    logic [3:0] a;
    a = 4'hF;
    if ((t % SD) >= G && en[slot_of(t)]) a[slot_of(t)] = 1'b0;
    return a;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= 0;
      m_val <= '0; m_dp <= '0; m_en <= '0;
      p_val <= '0; p_dp <= '0; p_en <= '0;
      m_flag <= 1'b0;
      e_seg <= 7'h00; e_seg2 <= 7'h00;
      e_dp <= 1'b0; e_an <= 4'hF; e_ft <= 1'b0;
    end else begin
      e_seg  <= exp_seg(m_t, m_val, lz_en, 1'b1);
      e_seg2 <= exp_seg(m_t, m_val, lz_en, 1'b0);
      e_dp   <= !is_blank(m_t, m_val, lz_en) && m_dp[slot_of(m_t)];
      e_an   <= exp_an(m_t, m_en);
      e_ft   <= at_boundary(m_t);
      if (at_boundary(m_t)) begin
        m_flag <= 1'b0;
        if (load) begin
          m_val <= value; m_dp <= dp_in; m_en <= digit_en;
        end else if (m_flag) begin
          m_val <= p_val; m_dp <= p_dp; m_en <= p_en;
        end
      end else if (load) begin
        p_val <= value; p_dp <= dp_in; p_en <= digit_en;
        m_flag <= 1'b1;
      end
      m_t <= m_t + 1;
    end
  end

  // per-frame capture of what each lit digit showed
  logic [6:0] cs [N];
  logic [6:0] cs2 [N];
  logic       cd [N];
  int         on [N];
  bit         mix [N];

  task automatic grab(input int load_at, input logic [15:0] lv,
                      input logic [3:0] le);
    for (int k = 0; k < N; k++) begin
      on[k] = 0; mix[k] = 0; cs[k] = 7'h55; cs2[k] = 7'h55; cd[k] = 1'b0;
    end
    for (int c = 0; c < SD * N; c++) begin
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (an[k] === 1'b0) begin
          if (on[k] > 0 && (cs[k] !== seg || cd[k] !== dp)) mix[k] = 1;
          cs[k] = seg; cd[k] = dp; on[k]++;
        end
        if (an2[k] === 1'b0) cs2[k] = seg2;
      end
      if (c == load_at) begin
        value = lv; digit_en = le; dp_in = 4'h0; load = 1'b1;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] e);
    @(negedge clk);
    value = v; dp_in = d; digit_en = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick;
    bit got;
    got = 0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = (frame_tick === 1'b1);
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL wait_tick: no frame_tick within 64 clocks");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({seg, dp, an, frame_tick} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hex: got %h want %h",
               {seg, dp, an, frame_tick}, {7'h00, 1'b0, 4'hF, 1'b0});
    end
    n_chk++;
    if ({seg2, dp2, an2, frame_tick2} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_dec: got %h want %h",
               {seg2, dp2, an2, frame_tick2}, {7'h00, 1'b0, 4'hF, 1'b0});
    end
    rst = 1'b0;
  endtask

  task automatic test_scan;
    int cnt;
    bit an_ok;
    logic [3:0] w;
    cnt = 0; an_ok = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cnt++;
      if (an !== 4'hF) an_ok = 0;
      if (frame_tick === 1'b1) break;
    end
    n_chk++;
    if (cnt != 16) begin
      n_fail++;
      $display("FAIL first_tick: got %0d clocks want 16", cnt);
    end
    n_chk++;
    if (!an_ok) begin
      n_fail++;
      $display("FAIL an_after_reset: anode lit got 1 want 0");
    end
    do_load(16'h0000, 4'h0, 4'hF);
    wait_tick;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      w = 4'b0001 << ((j / 4) % 4);
      w = ((j % 4) == 0) ? 4'hF : ~w;
      n_chk++;
      if (an !== w || frame_tick !== ((j % 16) == 15)) begin
        n_fail++;
        $display("FAIL scan_seq[%0d]: got an=%b ft=%b want an=%b ft=%b",
                 j, an, frame_tick, w, ((j % 16) == 15));
      end
    end
  endtask

  task automatic test_decode;
    logic [6:0] w1 [N];
    logic [6:0] w2 [N];
    w1 = '{7'h79, 7'h7B, 7'h77, 7'h47};
    w2 = '{7'h79, 7'h7B, 7'h00, 7'h00};
    do_load(16'hFA93, 4'h0, 4'hF);
    wait_tick;
    grab(-1, 16'h0, 4'h0);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (cs[k] !== w1[k] || cs2[k] !== w2[k] || cd[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL decode[%0d]: got %h/%h dp=%b want %h/%h dp=0",
                 k, cs[k], cs2[k], cd[k], w1[k], w2[k]);
      end
    end
  endtask

  task automatic test_midframe;
    logic [6:0] wa [N];
    logic [6:0] wb [N];
    wa = '{7'h33, 7'h79, 7'h6D, 7'h30};
    wb = '{7'h7F, 7'h70, 7'h5F, 7'h5B};
    do_load(16'h1234, 4'h0, 4'hF);
    wait_tick;
    grab(6, 16'h5678, 4'hF);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (cs[k] !== wa[k] || mix[k] || on[k] != SD - G) begin
        n_fail++;
        $display("FAIL midframe_old[%0d]: got %h mix=%0d on=%0d want %h",
                 k, cs[k], mix[k], on[k], wa[k]);
      end
    end
    grab(-1, 16'h0, 4'h0);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (cs[k] !== wb[k] || mix[k] || on[k] != SD - G) begin
        n_fail++;
        $display("FAIL midframe_new[%0d]: got %h mix=%0d on=%0d want %h",
                 k, cs[k], mix[k], on[k], wb[k]);
      end
    end
  endtask

  task automatic test_lz;
    logic [6:0] ws [N];
    logic       wd [N];
    lz_en = 1'b1;
    do_load(16'h0050, 4'hF, 4'hF);
    wait_tick;
    grab(-1, 16'h0, 4'h0);
    ws = '{7'h7E, 7'h5B, 7'h00, 7'h00};
    wd = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (cs[k] !== ws[k] || cd[k] !== wd[k]) begin
        n_fail++;
        $display("FAIL lz_0050[%0d]: got %h dp=%b want %h dp=%b",
                 k, cs[k], cd[k], ws[k], wd[k]);
      end
    end
    do_load(16'h0000, 4'hF, 4'hF);
    wait_tick;
    grab(-1, 16'h0, 4'h0);
    ws = '{7'h7E, 7'h00, 7'h00, 7'h00};
    wd = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (cs[k] !== ws[k] || cd[k] !== wd[k]) begin
        n_fail++;
        $display("FAIL lz_0000[%0d]: got %h dp=%b want %h dp=%b",
                 k, cs[k], cd[k], ws[k], wd[k]);
      end
    end
    lz_en = 1'b0;
    wait_tick;
    grab(-1, 16'h0, 4'h0);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (cs[k] !== 7'h7E || cd[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL lz_live_off[%0d]: got %h dp=%b want 7e dp=1",
                 k, cs[k], cd[k]);
      end
    end
  endtask

  task automatic test_digit_en;
    logic [6:0] wn [N];
    wn = '{7'h5F, 7'h70, 7'h7F, 7'h7B};
    do_load(16'h1234, 4'h0, 4'b0101);
    wait_tick;
    for (int f = 0; f < 2; f++) begin
      grab(-1, 16'h0, 4'h0);
      n_chk++;
      if (on[1] != 0 || on[3] != 0 || on[0] != 3 || on[2] != 3) begin
        n_fail++;
        $display("FAIL digit_en[%0d]: got on=%0d,%0d,%0d,%0d want 3,0,3,0",
                 f, on[0], on[1], on[2], on[3]);
      end
    end
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      if (j == 15) begin
        value = 16'h9876; dp_in = 4'h0; digit_en = 4'hF; load = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0;
    n_chk++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_tick: got %b want 1", frame_tick);
    end
    grab(-1, 16'h0, 4'h0);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (cs[k] !== wn[k] || mix[k] || on[k] != 3) begin
        n_fail++;
        $display("FAIL boundary_load[%0d]: got %h on=%0d want %h on=3",
                 k, cs[k], on[k], wn[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    int ftbad;
    do_load(16'h1111, 4'h0, 4'hF);
    wait_tick;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 3) begin
        value = 16'h4321; digit_en = 4'hF; load = 1'b1;
      end
      if (j == 4) load = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({seg, dp, an, frame_tick} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h",
               {seg, dp, an, frame_tick}, {7'h00, 1'b0, 4'hF, 1'b0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0; ftbad = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (seg !== 7'h7E || dp !== 1'b0 || an !== 4'hF) bad++;
      if (frame_tick !== ((c % 16) == 0)) ftbad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_discard: got %0d bad clocks want 0", bad);
    end
    n_chk++;
    if (ftbad != 0) begin
      n_fail++;
      $display("FAIL reset_restart: got %0d tick errors want 0", ftbad);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      n_chk++;
      if ({seg, dp, an, frame_tick} !== {e_seg, e_dp, e_an, e_ft}) begin
        n_fail++;
        $display("FAIL random_hex@%0d: got %h want %h", c,
                 {seg, dp, an, frame_tick}, {e_seg, e_dp, e_an, e_ft});
      end
      n_chk++;
      if ({seg2, dp2, an2, frame_tick2} !== {e_seg2, e_dp, e_an, e_ft}) begin
        n_fail++;
        $display("FAIL random_dec@%0d: got %h want %h", c,
                 {seg2, dp2, an2, frame_tick2}, {e_seg2, e_dp, e_an, e_ft});
      end
      load = ($urandom_range(5) == 0);
      if (load) begin
        value = 16'($urandom);
        case ($urandom_range(3))
          0: value = value & 16'h00FF;
          1: value = value & 16'h000F;
          2: value = 16'h0000;
          default: ;
        endcase
        dp_in = 4'($urandom);
        digit_en = 4'($urandom);
      end
      if ($urandom_range(49) == 0) lz_en = ~lz_en;
      rst = rst ? 1'b0 : ($urandom_range(399) == 0);
    end
    load = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_decode;
    test_midframe;
    test_lz;
    test_digit_en;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
